ps2_cmd_seq: RTL



---
 rtl/ps2_cmd_seq.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/ps2_cmd_seq.sv
// Host-side PS/2 command sequencer: sends a command (plus optional argument) through
// the controller, collects the device response with retries, and forwards scan codes.

package ps2_pkg;
    typedef struct packed {
        logic parity_error;
        logic frame_error;
        logic clk_timeout;
        logic rqst_timeout;
    } flags_t;
endpackage

module ps2_cmd_seq #(
    parameter int MAX_RETRY   = 3,
    parameter int ACK_TIMEOUT = 2_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [7:0]           cmd_byte,
    input  logic                 cmd_has_arg,
    input  logic [7:0]           cmd_arg,
    output logic                 rsp_valid,
    output logic [2:0]           rsp_code,
    output logic                 rx_valid,
    output logic [7:0]           rx_byte,
    output logic                 rx_err,
    output logic                 ps2_en,
    output logic                 ps2_tx_rqst,
    output logic [7:0]           ps2_tx_data,
    input  logic                 ps2_valid,
    input  ps2_pkg::flags_t      ps2_flags,
    input  logic [7:0]           ps2_rx_data
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    localparam logic [2:0] RSP_OK         = 3'd0;
    localparam logic [2:0] RSP_TX_FAIL    = 3'd1;
    localparam logic [2:0] RSP_RESEND_EXH = 3'd2;
    localparam logic [2:0] RSP_ACK_TO     = 3'd3;
    localparam logic [2:0] RSP_BAD_RSP    = 3'd4;

    typedef enum logic [2:0] {
        S_RECOVER,
        S_IDLE,
        S_TX,
        S_TX_REL,
        S_WAIT_RSP
    } state_t;

    state_t        state, state_d;
    logic          tgt_tx, tgt_tx_d;
    logic [7:0]    cur, cur_d;
    logic [7:0]    arg, arg_d;
    logic          has_arg, has_arg_d;
    logic          arg_sent, arg_sent_d;
    logic [RW-1:0] retry_cnt, retry_cnt_d;
    logic [TW-1:0] to_cnt, to_cnt_d;
    logic          rsp_valid_d, rx_valid_d, rx_err_d;
    logic [2:0]    rsp_code_d;
    logic [7:0]    rx_byte_d;

    logic          ps2_err;
    logic          fail, fail_line, fin;
    logic [2:0]    fin_code;

    assign ps2_err = ps2_flags.parity_error | ps2_flags.frame_error |
                     ps2_flags.clk_timeout  | ps2_flags.rqst_timeout;

    // cmd: a command transfers on a rising edge where cmd_valid && cmd_ready; a received
    // byte in the same cycle has priority, so cmd_ready drops combinationally with ps2_valid.
    assign cmd_ready   = (state == S_IDLE) && !ps2_valid;
    assign ps2_en      = (state != S_RECOVER);
    assign ps2_tx_rqst = (state == S_TX);
    assign ps2_tx_data = cur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_RECOVER;
            tgt_tx    <= 1'b0;
            cur       <= '0;
            arg       <= '0;
            has_arg   <= 1'b0;
            arg_sent  <= 1'b0;
            retry_cnt <= '0;
            to_cnt    <= '0;
            rsp_valid <= 1'b0;
            rsp_code  <= RSP_OK;
            rx_valid  <= 1'b0;
            rx_byte   <= '0;
            rx_err    <= 1'b0;
        end else begin
            state     <= state_d;
            tgt_tx    <= tgt_tx_d;
            cur       <= cur_d;
            arg       <= arg_d;
            has_arg   <= has_arg_d;
            arg_sent  <= arg_sent_d;
            retry_cnt <= retry_cnt_d;
            to_cnt    <= to_cnt_d;
            rsp_valid <= rsp_valid_d;
            rsp_code  <= rsp_code_d;
            rx_valid  <= rx_valid_d;
            rx_byte   <= rx_byte_d;
            rx_err    <= rx_err_d;
        end
    end

    always_comb begin
        state_d     = state;
        tgt_tx_d    = tgt_tx;
        cur_d       = cur;
        arg_d       = arg;
        has_arg_d   = has_arg;
        arg_sent_d  = arg_sent;
        retry_cnt_d = retry_cnt;
        to_cnt_d    = to_cnt;
        rsp_valid_d = 1'b0;
        rsp_code_d  = rsp_code;
        rx_valid_d  = 1'b0;
        rx_byte_d   = rx_byte;
        rx_err_d    = 1'b0;
        fail        = 1'b0;
        fail_line   = 1'b0;
        fin         = 1'b0;
        fin_code    = RSP_OK;

        case (state)
            S_RECOVER: begin
                state_d = tgt_tx ? S_TX : S_IDLE;
            end
            S_IDLE: begin
                if (ps2_valid) begin
                    if (ps2_err) begin
                        rx_err_d = 1'b1;
                        tgt_tx_d = 1'b0;
                        state_d  = S_RECOVER;
                    end else begin
                        rx_byte_d  = ps2_rx_data;
                        rx_valid_d = 1'b1;
                    end
                end else if (cmd_valid) begin
                    cur_d       = cmd_byte;
                    arg_d       = cmd_arg;
                    has_arg_d   = cmd_has_arg;
                    arg_sent_d  = 1'b0;
                    retry_cnt_d = '0;
                    state_d     = S_TX;
                end
            end
            S_TX: begin
                if (ps2_valid) begin
                    if (ps2_err) begin
                        fail      = 1'b1;
                        fail_line = 1'b1;
                    end else begin
                        state_d = S_TX_REL;
                    end
                end
            end
            S_TX_REL: begin
                to_cnt_d = '0;
                state_d  = S_WAIT_RSP;
            end
            S_WAIT_RSP: begin
                to_cnt_d = to_cnt + TW'(1);
                if (ps2_valid) begin
                    if (ps2_err) begin
                        fail      = 1'b1;
                        fail_line = 1'b1;
                    end else if (ps2_rx_data == 8'hFA) begin
                        if (has_arg && !arg_sent) begin
                            cur_d       = arg;
                            arg_sent_d  = 1'b1;
                            retry_cnt_d = '0;
                            state_d     = S_TX;
                        end else begin
                            fin = 1'b1;
                        end
                    end else if (ps2_rx_data == 8'hFE) begin
                        fail = 1'b1;
                    end else begin
                        fin      = 1'b1;
                        fin_code = RSP_BAD_RSP;
                    end
                end else if (to_cnt == TW'(ACK_TIMEOUT - 1)) begin
                    fin      = 1'b1;
                    fin_code = RSP_ACK_TO;
                end
            end
            default: begin
                state_d = S_RECOVER;
            end
        endcase

        // A retry re-sends cur after one inhibit cycle; exhaustion ends the command.
        if (fail) begin
            if (retry_cnt < RW'(MAX_RETRY)) begin
                retry_cnt_d = retry_cnt + RW'(1);
                tgt_tx_d    = 1'b1;
                state_d     = S_RECOVER;
            end else begin
                fin      = 1'b1;
                fin_code = fail_line ? RSP_TX_FAIL : RSP_RESEND_EXH;
            end
        end

        if (fin) begin
            rsp_valid_d = 1'b1;
            rsp_code_d  = fin_code;
            tgt_tx_d    = 1'b0;
            state_d     = (fin_code == RSP_OK) ? S_IDLE : S_RECOVER;
        end
    end

endmodule
